// File: rtl/model.sv
// Write-only history FIFO: presents the oldest retained entry on dout, overwrites the oldest on a
// write while full. Define MODEL_DROP_NEW_EN to discard writes while full instead.
module model #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2   // legal range 2..64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  at_capacity;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        at_capacity = (count_q == CNT_FULL);

        if (wr) begin
            if (!at_capacity) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                count_d         = count_q + 1'b1;
            end else begin
`ifdef MODEL_DROP_NEW_EN
                // Full: the incoming word is dropped so the oldest history survives.
                mem_d = mem_q;
`else
                // Full: wr_ptr == rd_ptr here, so this write replaces the oldest entry.
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                rd_ptr_d        = ptr_inc(rd_ptr_q);
`endif
            end
        end

        // Outputs are computed from next state so a write shows up right after its edge.
        dout_d  = (count_d == '0) ? '0 : mem_d[rd_ptr_d];
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_model.sv
// Bench for model: a DEPTH=2 and a DEPTH=4 instance share stimulus and are each checked against
// a queue-based reference; honours MODEL_DROP_NEW_EN.
module tb_model;

    logic       clk;
    logic       resetn;
    logic [7:0] din;
    logic       wr;
    logic [7:0] dout2, dout4;
    logic       full2, full4, empty2, empty4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q2[$];
    logic [7:0] q4[$];

    model #(.DATA_WIDTH(8), .DEPTH(2)) u_dut2 (
        .clk   (clk),
        .resetn(resetn),
        .din   (din),
        .wr    (wr),
        .dout  (dout2),
        .full  (full2),
        .empty (empty2)
    );

    model #(.DATA_WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .resetn(resetn),
        .din   (din),
        .wr    (wr),
        .dout  (dout4),
        .full  (full4),
        .empty (empty4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded history list, oldest at the front.
    task automatic model_push(inout logic [7:0] q[$], input int depth, input logic [7:0] d);
        if (q.size() < depth) begin
            q.push_back(d);
        end else begin
`ifndef MODEL_DROP_NEW_EN
            void'(q.pop_front());
            q.push_back(d);
`endif
        end
    endtask

    task automatic check_models();
        check("dout2", {24'd0, dout2}, (q2.size() == 0) ? 32'd0 : {24'd0, q2[0]});
        check("full2", {31'd0, full2}, {31'd0, q2.size() == 2});
        check("empty2", {31'd0, empty2}, {31'd0, q2.size() == 0});
        check("dout4", {24'd0, dout4}, (q4.size() == 0) ? 32'd0 : {24'd0, q4[0]});
        check("full4", {31'd0, full4}, {31'd0, q4.size() == 4});
        check("empty4", {31'd0, empty4}, {31'd0, q4.size() == 0});
    endtask

    // Apply one cycle of stimulus, update the reference at the edge, sample 1 unit later.
    task automatic step(input logic wr_v, input logic [7:0] din_v);
        wr  = wr_v;
        din = din_v;
        @(posedge clk);
        if (resetn && wr_v) begin
            model_push(q2, 2, din_v);
            model_push(q4, 4, din_v);
        end
        #1;
        check_models();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        q2.delete();
        q4.delete();
        wr = 1'b0;
        @(posedge clk);
        #1;
        check_models();
        resetn = 1'b1;
    endtask

    // Pulse reset between edges; outputs must clear before the next edge.
    task automatic async_reset_pulse();
        #2;
        resetn = 1'b0;
        q2.delete();
        q4.delete();
        #1;
        check_models();
        resetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'd5, 8'd5, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'd3, 8'd5, 1'b1, 1'b0};
`ifdef MODEL_DROP_NEW_EN
        vecs[3] = '{1'b1, 8'd6, 8'd5, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'd6, 8'd5, 1'b1, 1'b0};
`else
        vecs[3] = '{1'b1, 8'd6, 8'd3, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'd6, 8'd6, 1'b1, 1'b0};
`endif

        resetn = 1'b0;
        wr     = 1'b0;
        din    = 8'd0;

        // Held in reset with writes toggling: nothing may be stored.
        for (int i = 0; i < 6; i++) begin
            step(i[0], 8'(8'hA0 + i));
            check("rst_dout2", {24'd0, dout2}, 32'd0);
            check("rst_empty4", {31'd0, empty4}, 32'd1);
        end
        resetn = 1'b1;

        // Fill then overwrite / drop, DEPTH=2 table.
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].wr, vecs[i].din);
            check("vec_dout", {24'd0, dout2}, {24'd0, vecs[i].dout});
            check("vec_full", {31'd0, full2}, {31'd0, vecs[i].full});
            check("vec_empty", {31'd0, empty2}, {31'd0, vecs[i].empty});
        end

        // Idle hold after fill.
        do_reset();
        step(1'b1, 8'd5);
        step(1'b1, 8'd3);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'($urandom));
            check("idle_dout", {24'd0, dout2}, 32'd5);
            check("idle_full", {31'd0, full2}, 32'd1);
            check("idle_empty", {31'd0, empty2}, 32'd0);
        end

        // Mid-stream asynchronous reset on the DEPTH=4 instance.
        do_reset();
        step(1'b1, 8'd1);
        step(1'b1, 8'd2);
        step(1'b1, 8'd3);
        check("mid_pre_dout4", {24'd0, dout4}, 32'd1);
        async_reset_pulse();
        check("mid_rst_dout4", {24'd0, dout4}, 32'd0);
        check("mid_rst_empty4", {31'd0, empty4}, 32'd1);
        check("mid_rst_full4", {31'd0, full4}, 32'd0);
        step(1'b1, 8'd9);
        check("mid_post_dout4", {24'd0, dout4}, 32'd9);
        check("mid_post_empty4", {31'd0, empty4}, 32'd0);
        check("mid_post_full4", {31'd0, full4}, 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                async_reset_pulse();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
